// File: rtl/interp_upsampler_pkg.sv
//============================================================================
// Module : interp_upsampler_pkg
// Brief  : Shared widths, state encoding, defaults and interpolation helper
//          for the interpolating upsampler.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package interp_upsampler_pkg;

    localparam int SAMPLE_W         = 16;
    localparam int DIFF_W           = 17;
    localparam int DEF_CE_DIV       = 4;
    localparam int DEF_LOG2_RATIO   = 2;
    localparam int DEF_FIFO_DEPTH   = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // prev + floor((cur - prev) * phase / 2^log2_ratio); phase holds up to 8 bits.
    function automatic logic signed [SAMPLE_W-1:0] interp_value(
        input logic signed [SAMPLE_W-1:0] prev,
        input logic signed [SAMPLE_W-1:0] cur,
        input logic        [7:0]          phase,
        input int                         log2_ratio
    );
        logic signed [DIFF_W-1:0] diff;
        logic signed [DIFF_W+8:0] prod;
        diff = $signed({cur[SAMPLE_W-1], cur}) - $signed({prev[SAMPLE_W-1], prev});
        prod = diff * $signed({1'b0, phase});
        return SAMPLE_W'((prod >>> log2_ratio) + (DIFF_W+9)'(prev));
    endfunction

endpackage

`default_nettype wire

// File: rtl/interp_upsampler_sample_fifo.sv
//============================================================================
// Module : sample_fifo
// Brief  : Show-ahead synchronous FIFO for incoming audio samples.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module sample_fifo
    import interp_upsampler_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   c_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/interp_upsampler.sv
//============================================================================
// Module : interp_upsampler
// Brief  : Buffers audio samples and linearly interpolates 2^LOG2_RATIO steps
//          per sample, paced by a CE_DIV clock-enable strobe for the DAC.
//          Define INTERP_UPSAMPLER_UNDERRUN_MUTE_EN to ramp to silence on
//          underrun instead of holding the last sample.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module interp_upsampler
    import interp_upsampler_pkg::*;
#(
    parameter int CE_DIV     = DEF_CE_DIV,
    parameter int LOG2_RATIO = DEF_LOG2_RATIO,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                i_clk,
    input  logic                i_res,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [SAMPLE_W-1:0] o_func,
    output logic                o_ce,
    output logic                o_underrun
);

    localparam int                    CNT_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [CNT_W-1:0]      c_CNT_MAX = CNT_W'(CE_DIV - 1);
    localparam logic [LOG2_RATIO-1:0] c_PH_MAX  = '1;

    logic [CNT_W-1:0]           r_cnt;
    logic                       r_ce;
    state_t                     r_state;
    logic [LOG2_RATIO-1:0]      r_phase;
    logic signed [SAMPLE_W-1:0] r_prev;
    logic signed [SAMPLE_W-1:0] r_cur;
    logic [SAMPLE_W-1:0]        r_func;
    logic                       r_under;

    logic                       w_full;
    logic                       w_empty;
    logic [SAMPLE_W-1:0]        w_fifo_data;
    logic                       w_push;
    logic                       w_tick;
    logic                       w_pop;
    state_t                     w_state_nxt;
    logic [LOG2_RATIO-1:0]      w_phase_nxt;
    logic signed [SAMPLE_W-1:0] w_prev_nxt;
    logic signed [SAMPLE_W-1:0] w_cur_nxt;
    logic                       w_under_nxt;

    assign w_push = i_valid && !w_full;
    assign w_tick = r_ce && ((r_state == IDLE) || (r_phase == c_PH_MAX));
    assign w_pop  = w_tick && !w_empty;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_res   (i_res),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_sample),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_prev_nxt  = r_prev;
        w_cur_nxt   = r_cur;
        w_under_nxt = r_under;
        if (r_ce) begin
            if (r_state == IDLE) begin
                if (!w_empty) begin
                    w_state_nxt = RUN;
                    w_cur_nxt   = w_fifo_data;
                    w_prev_nxt  = '0;
                    w_phase_nxt = '0;
                end
            end else begin
                w_phase_nxt = r_phase + LOG2_RATIO'(1);
                if (w_tick) begin
                    w_prev_nxt = r_cur;
                    if (!w_empty) begin
                        w_cur_nxt = w_fifo_data;
                    end else begin
                        w_under_nxt = 1'b1;
`ifdef INTERP_UPSAMPLER_UNDERRUN_MUTE_EN
                        w_cur_nxt = '0;
`endif
                    end
                end
            end
        end
    end

    // o_func is computed from the post-update operands so it tracks the new phase.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_cnt   <= '0;
            r_ce    <= 1'b0;
            r_state <= IDLE;
            r_phase <= '0;
            r_prev  <= '0;
            r_cur   <= '0;
            r_func  <= '0;
            r_under <= 1'b0;
        end else begin
            r_cnt   <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
            r_ce    <= (r_cnt == c_CNT_MAX);
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_prev  <= w_prev_nxt;
            r_cur   <= w_cur_nxt;
            r_under <= w_under_nxt;
            if (r_ce) begin
                r_func <= (w_state_nxt == RUN) ?
                          interp_value(w_prev_nxt, w_cur_nxt, 8'(w_phase_nxt), LOG2_RATIO) : '0;
            end
        end
    end

    assign o_ready    = !w_full;
    assign o_func     = r_func;
    assign o_ce       = r_ce;
    assign o_underrun = r_under;

endmodule

`default_nettype wire

// File: doc/interp_upsampler.md
Name: interp_upsampler

Overview:
- Upstream feeder for the sigma-delta DAC stage.
- Accepts 16-bit signed audio samples at the audio rate over a valid/ready handshake and buffers them in a small FIFO.
- Linearly interpolates between consecutive samples, 2^LOG2_RATIO steps per sample.
- Produces the DAC's 16-bit signed input word plus the one-cycle clock-enable strobe that advances the modulator.

Parameters:
- CE_DIV, 4: i_clk cycles per o_ce strobe; legal range 2..65536.
- LOG2_RATIO, 2: interpolation steps per input sample = 2^LOG2_RATIO; legal range 1..8.
- FIFO_DEPTH, 4: input FIFO entries; power of two, >=2.

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_res  in  1  synchronous reset, active-high
- i_sample  in  16  signed two's-complement input sample
- i_valid  in  1  i_sample valid
- o_ready  out  1  FIFO can accept; equals !full
- o_func  out  16  signed interpolated word to the DAC
- o_ce  out  1  one-cycle DAC clock-enable strobe
- o_underrun  out  1  sticky flag: FIFO was empty when a sample was required

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high on i_res, sampled at the i_clk rising edge; it overrides all other activity, including mid-transfer.
  - Reset values: o_func=0, o_ce=0, o_underrun=0, o_ready=1; FIFO empty; ce counter=0; phase=0; prev=cur=0; state=IDLE.
- Strobe generation:
  - ce counter runs 0..CE_DIV-1 and wraps.
  - o_ce is registered and is high for exactly the one cycle after the counter reaches CE_DIV-1.
  - The counter runs in both states.
- Input FIFO:
  - Push when i_valid && o_ready.
  - A pop occurs only on a "tick": a cycle with o_ce=1 and phase==2^LOG2_RATIO-1 (RUN), or any o_ce cycle (IDLE).
  - Push and pop in the same cycle leave the count unchanged.
  - When full, o_ready=0 and i_valid is ignored.
- States:
  - IDLE: o_func holds 0. On an o_ce cycle with the FIFO non-empty: pop into cur, prev<=0, phase<=0, go to RUN.
  - RUN, on each o_ce cycle: phase<=phase+1 (wraps mod 2^LOG2_RATIO). At a tick: prev<=cur; cur<=popped sample, or see underrun.
  - RUN never returns to IDLE except by reset.
- Output arithmetic:
  - diff = sign-extended cur minus sign-extended prev, 17 bits signed.
  - o_func = prev + ((diff*phase) >>> LOG2_RATIO).
  - Arithmetic shift, i.e. floor. The result always lies within [min(prev,cur), max(prev,cur)], so no saturation is needed.
- Output timing:
  - o_func is registered and updates on the cycle after each o_ce, using the post-update phase/prev/cur.
  - o_func is therefore stable for CE_DIV-1 cycles before and through the next o_ce.
- Underrun:
  - Condition: FIFO empty at a RUN tick.
  - No pop occurs; prev<=cur; cur unchanged (hold, see Optional Feature).
  - o_underrun<=1 and stays set until reset.

Optional Feature:
- Macro: INTERP_UPSAMPLER_UNDERRUN_MUTE_EN.
- Defined: on underrun, cur<=0, so the output ramps linearly from the last value to silence over one sample period and then stays at 0 while starved. Normal interpolation resumes at the next tick with FIFO data.
- Undefined: cur is held on underrun, so the output flat-lines at the last sample.
- o_underrun behaviour is identical in both builds.

Decomposition:
- Shared package interp_upsampler_pkg:
  - SAMPLE_W=16, DIFF_W=17
  - state enum {IDLE, RUN}
  - default parameter constants
- One natural sub-module: sample_fifo.
  - Synchronous FIFO with the same reset.
  - Ports: push, pop, data in, data out, full, empty.
  - Pop data is valid in the same cycle (show-ahead).
- Interpolator, strobe counter and state machine stay in the top level.

Test Plan:
- Ramp (CE_DIV=4, LOG2_RATIO=2): after reset push 0x4000, then 0x0000 → o_ce every 4 cycles; o_func sequence 0x0000,0x1000,0x2000,0x3000,0x4000,0x3000,0x2000,0x1000.
- Full-scale swing: prev=0x7FFF, cur=0x8000 → o_func 0x7FFF, 0x3FFF, 0xFFFF, 0xBFFF.
  - Phase steps: phase0 = 0x7FFF; phase1 = 0x7FFF-0x4000; phase2 = 0x7FFF-0x8000; phase3 = 0x7FFF-0xC000.
  - Check floor behaviour and that no wrap occurs.
- Backpressure: hold i_valid=1 with no ticks → o_ready drops after 4 pushes; 5th sample not accepted; o_ready rises the cycle after the first pop.
- Underrun: stop feeding after 0x2000 → o_underrun=1 at the starved tick.
  - Macro off: o_func holds 0x2000.
  - Macro on: o_func ramps 0x2000,0x1800,0x1000,0x0800,0x0000.
- Reset mid-ramp: assert i_res for 1 cycle in RUN → next cycle o_func=0, o_ce=0, o_underrun=0, o_ready=1, FIFO empty; the module restarts from IDLE.
